// File: rtl/rob_pkg.sv
// ============================================================================
// Module      : rob_pkg
// Description : Shared constants and entry type for the reorder-buffer FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_pkg;

    localparam int AXI_DATA_WIDTH = 64;
    localparam int TID_WIDTH      = 8;
    localparam int FIFO_SIZE      = 16;
    localparam int FIFO_WIDTH     = TID_WIDTH + AXI_DATA_WIDTH;

    // One buffered response: transaction ID on top, payload below.
    typedef struct packed {
        logic [TID_WIDTH-1:0]      tid;
        logic [AXI_DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage : rob_pkg

`default_nettype wire

// File: rtl/rob_sync_fifo_if.sv
// ============================================================================
// Module      : rob_sync_fifo_if
// Description : Push/pop/status bundle for rob_sync_fifo. The count_o
//               signal exists only when ROB_FIFO_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_sync_fifo_if
    import rob_pkg::*;
#(
    parameter int DATA_WIDTH = rob_pkg::FIFO_WIDTH,
    parameter int ADDR_W     = $clog2(rob_pkg::FIFO_SIZE)
);

    logic                  full_o;
    logic                  write_en_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  empty_o;
    logic                  read_en_i;
    logic [DATA_WIDTH-1:0] read_data_o;
`ifdef ROB_FIFO_COUNT_EN
    logic [ADDR_W:0]       count_o;
`endif

    // FIFO side
    modport slave (
        input  write_en_i,
        input  write_data_i,
        input  read_en_i,
        output full_o,
        output empty_o,
`ifdef ROB_FIFO_COUNT_EN
        output count_o,
`endif
        output read_data_o
    );

    // Producer/consumer side
    modport master (
        output write_en_i,
        output write_data_i,
        output read_en_i,
        input  full_o,
        input  empty_o,
`ifdef ROB_FIFO_COUNT_EN
        input  count_o,
`endif
        input  read_data_o
    );

endinterface : rob_sync_fifo_if

`default_nettype wire

// File: rtl/rob_fifo_mem.sv
// ============================================================================
// Module      : rob_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, one synchronous write port
//               and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_fifo_mem #(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [ADDR_W-1:0]     waddr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    input  wire logic [ADDR_W-1:0]     raddr,
    output logic      [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the pushed entry; storage needs no reset since empty masks it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : rob_fifo_mem

`default_nettype wire

// File: rtl/rob_sync_fifo.sv
// ============================================================================
// Module      : rob_sync_fifo
// Description : Single-clock show-ahead FIFO for the reorder buffer. The head
//               entry is presented combinationally whenever non-empty.
//               Define ROB_FIFO_COUNT_EN to add the count_o occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_sync_fifo #(
    parameter int DATA_WIDTH = rob_pkg::FIFO_WIDTH,
    parameter int FIFO_SIZE  = rob_pkg::FIFO_SIZE
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rob_sync_fifo_if.slave  bus
);

    import rob_pkg::*;

    localparam int ADDR_W = $clog2(FIFO_SIZE);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W-1:0]     wr_idx;
    logic [ADDR_W-1:0]     rd_idx;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push = bus.write_en_i && !full;
    assign pop  = bus.read_en_i && !empty;

    // Advance pointers on accepted operations; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    rob_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_SIZE),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_idx),
        .wdata (bus.write_data_i),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    // Stale storage is never exposed: an empty FIFO reads as zero.
    assign bus.read_data_o = empty ? '0 : mem_rdata;

`ifdef ROB_FIFO_COUNT_EN
    assign bus.count_o = wr_ptr - rd_ptr;
`endif

endmodule : rob_sync_fifo

`default_nettype wire

// File: tb/tb_rob_sync_fifo.sv
// ============================================================================
// Module      : tb_rob_sync_fifo
// Description : Self-checking bench for rob_sync_fifo: a table of directed
//               vectors plus hand-written multi-cycle sequences checked
//               against a queue model. Count checks apply with
//               ROB_FIFO_COUNT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_sync_fifo;

    localparam int DW = rob_pkg::FIFO_WIDTH;
    localparam int FS = rob_pkg::FIFO_SIZE;
    localparam int AW = $clog2(FS);

    logic clk;
    logic rst_n;

    rob_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    rob_sync_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mq[$];

    typedef struct {
        logic          rst_n;
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          exp_empty;
        logic          exp_full;
        logic [DW-1:0] exp_rd;
        logic [AW:0]   exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare DUT outputs to the queue model's view.
    task automatic check_model(input string tag);
        logic [DW-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".empty"}, bus.empty_o, mq.size() == 0);
        chk({tag, ".full"},  bus.full_o,  mq.size() == FS);
        chk({tag, ".rdata"}, bus.read_data_o, head);
`ifdef ROB_FIFO_COUNT_EN
        chk({tag, ".count"}, bus.count_o, mq.size());
`endif
    endtask

    // Drive one cycle, update the model with the pre-edge state, then check.
    task automatic cycle(input string tag, input logic r, input logic we,
                         input logic [DW-1:0] wd, input logic re);
        bit push_ok;
        bit pop_ok;
        rst_n            = r;
        bus.write_en_i   = we;
        bus.write_data_i = wd;
        bus.read_en_i    = re;
        push_ok = we && (mq.size() < FS);
        pop_ok  = re && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (!r) begin
            mq.delete();
        end else begin
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(wd);
        end
        rst_n            = 1'b1;
        bus.write_en_i   = 1'b0;
        bus.write_data_i = '0;
        bus.read_en_i    = 1'b0;
        check_model(tag);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.write_en_i   = 1'b0;
        bus.write_data_i = '0;
        bus.read_en_i    = 1'b0;

        // rst_n we  wd     re  empty full rdata  cnt
        vecs[0] = '{1'b0, 1'b0, 72'h0,  1'b0, 1'b1, 1'b0, 72'h0,  5'd0};
        vecs[1] = '{1'b0, 1'b0, 72'h0,  1'b0, 1'b1, 1'b0, 72'h0,  5'd0};
        vecs[2] = '{1'b1, 1'b1, 72'hA1, 1'b0, 1'b0, 1'b0, 72'hA1, 5'd1};
        vecs[3] = '{1'b1, 1'b0, 72'h0,  1'b1, 1'b1, 1'b0, 72'h0,  5'd0};
        vecs[4] = '{1'b1, 1'b0, 72'h0,  1'b1, 1'b1, 1'b0, 72'h0,  5'd0};
        vecs[5] = '{1'b1, 1'b1, 72'hB2, 1'b1, 1'b0, 1'b0, 72'hB2, 5'd1};
        vecs[6] = '{1'b1, 1'b1, 72'hC3, 1'b1, 1'b0, 1'b0, 72'hC3, 5'd1};
        vecs[7] = '{1'b1, 1'b1, 72'hD4, 1'b0, 1'b0, 1'b0, 72'hC3, 5'd2};
        vecs[8] = '{1'b1, 1'b0, 72'h0,  1'b1, 1'b0, 1'b0, 72'hD4, 5'd1};

        for (int i = 0; i < 9; i++) begin
            rst_n            = vecs[i].rst_n;
            bus.write_en_i   = vecs[i].we;
            bus.write_data_i = vecs[i].wd;
            bus.read_en_i    = vecs[i].re;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.empty", i), bus.empty_o, vecs[i].exp_empty);
            chk($sformatf("vec%0d.full", i),  bus.full_o,  vecs[i].exp_full);
            chk($sformatf("vec%0d.rdata", i), bus.read_data_o, vecs[i].exp_rd);
`ifdef ROB_FIFO_COUNT_EN
            chk($sformatf("vec%0d.count", i), bus.count_o, vecs[i].exp_cnt);
`endif
        end

        // Fill to capacity, drop a 17th push, drain in order.
        cycle("fill.rst", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < FS; i++) cycle("fill", 1'b1, 1'b1, DW'(i), 1'b0);
        chk("fill.full_after_16", bus.full_o, 1'b1);
        cycle("fill.drop", 1'b1, 1'b1, 72'h99, 1'b0);
        chk("fill.head_after_drop", bus.read_data_o, 72'h0);
        for (int i = 0; i < FS; i++) begin
            chk($sformatf("drain.val%0d", i), bus.read_data_o, DW'(i));
            cycle("drain", 1'b1, 1'b0, '0, 1'b1);
        end
        chk("drain.empty", bus.empty_o, 1'b1);

        // Half-full steady state across pointer wrap.
        cycle("ss.rst", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("ss.fill", 1'b1, 1'b1, DW'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("ss.order%0d", i), bus.read_data_o, DW'(8'h40 + i));
            cycle("ss.pp", 1'b1, 1'b1, DW'(8'h48 + i), 1'b1);
        end
`ifdef ROB_FIFO_COUNT_EN
        chk("ss.count8", bus.count_o, 5'd8);
`endif

        // Full with simultaneous push+pop: pop taken, push dropped.
        cycle("fpp.rst", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < FS; i++) cycle("fpp.fill", 1'b1, 1'b1, DW'(i), 1'b0);
        cycle("fpp.pp", 1'b1, 1'b1, 72'h77, 1'b1);
        chk("fpp.full", bus.full_o, 1'b0);
        chk("fpp.head", bus.read_data_o, 72'h1);
`ifdef ROB_FIFO_COUNT_EN
        chk("fpp.count15", bus.count_o, 5'd15);
`endif

        // Pop on empty leaves pointers alone; reset mid-traffic hides old head.
        cycle("pe.rst", 1'b0, 1'b0, '0, 1'b0);
        cycle("pe.badpop", 1'b1, 1'b0, '0, 1'b1);
        cycle("pe.push", 1'b1, 1'b1, 72'h5A, 1'b0);
        chk("pe.head_after_badpop", bus.read_data_o, 72'h5A);
        for (int i = 0; i < 4; i++) cycle("pe.fill", 1'b1, 1'b1, DW'(8'h60 + i), 1'b0);
        cycle("pe.midrst", 1'b0, 1'b1, 72'hEE, 1'b1);
        chk("pe.empty_after_rst", bus.empty_o, 1'b1);
        chk("pe.rdata_after_rst", bus.read_data_o, 72'h0);
        cycle("pe.newpush", 1'b1, 1'b1, 72'h3C, 1'b0);
        chk("pe.new_head", bus.read_data_o, 72'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rob_sync_fifo

`default_nettype wire
